// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
// Holds the debounce FSM state enum, the four active-low column drive
// patterns, the 5-bit frame candidate encoding (MSB set = no key), and the
// helper that turns one row sample into a candidate code.
package keypad_pkg;

    localparam int unsigned COL_W  = 4;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned CAND_W = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned DEB_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } kp_state_e;

    localparam logic [COL_W-1:0] COL_PAT0 = 4'b1110;
    localparam logic [COL_W-1:0] COL_PAT1 = 4'b1101;
    localparam logic [COL_W-1:0] COL_PAT2 = 4'b1011;
    localparam logic [COL_W-1:0] COL_PAT3 = 4'b0111;

    // NONE compares numerically greater than every real code (0..15),
    // so "lowest code in the frame" is a plain unsigned minimum.
    localparam logic [CAND_W-1:0] CAND_NONE = 5'b10000;

    // Active-low drive pattern for a column index.
    function automatic logic [COL_W-1:0] col_pattern(input logic [1:0] idx);
        logic [COL_W-1:0] pat;
        case (idx)
            2'd0:    pat = COL_PAT0;
            2'd1:    pat = COL_PAT1;
            2'd2:    pat = COL_PAT2;
            default: pat = COL_PAT3;
        endcase
        return pat;
    endfunction

    // Lowest pressed row in this column gives code 4*r + c, else NONE.
    function automatic logic [CAND_W-1:0] row_candidate(input logic [ROW_W-1:0] row,
                                                        input logic [1:0]       col_idx);
        logic [CAND_W-1:0] cand;
        cand = CAND_NONE;
        for (int r = 3; r >= 0; r--) begin
            if (!row[r]) begin
                cand = {1'b0, 2'(r), col_idx};
            end
        end
        return cand;
    endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column scanner: drives one active-low column at a time for SCAN_DIV
// cycles, samples the rows on the last dwell cycle, and reduces the four
// samples of a frame to the lowest pressed code.
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   row_i          - active-low row sense
//   col_o          - active-low column drive (registered)
//   frame_done_o   - one-cycle pulse after the column-3 sample
//   cand_o         - candidate of the last completed frame (valid with frame_done_o)
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ROW_W-1:0]  row_i,
    output logic [COL_W-1:0]  col_o,
    output logic              frame_done_o,
    output logic [CAND_W-1:0] cand_o
);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [CAND_W-1:0] acc_q, acc_d;
    logic              frame_done_q, frame_done_d;
    logic [CAND_W-1:0] cand_q, cand_d;

    logic              last_dwell_c;
    logic [CAND_W-1:0] sample_cand_c;
    logic [CAND_W-1:0] merged_c;

    // Dwell counting, column stepping and per-frame minimum reduction.
    always_comb begin
        div_d         = div_q;
        col_idx_d     = col_idx_q;
        col_d         = col_q;
        acc_d         = acc_q;
        frame_done_d  = 1'b0;
        cand_d        = cand_q;

        last_dwell_c  = (div_q == DIV_W'(SCAN_DIV - 1));
        sample_cand_c = row_candidate(row_i, col_idx_q);
        merged_c      = (sample_cand_c < acc_q) ? sample_cand_c : acc_q;

        if (last_dwell_c) begin
            div_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            col_d     = col_pattern(col_idx_q + 2'd1);
            if (col_idx_q == 2'd3) begin
                frame_done_d = 1'b1;
                cand_d       = merged_c;
                acc_d        = CAND_NONE;
            end else begin
                acc_d        = merged_c;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q        <= '0;
            col_idx_q    <= 2'd0;
            col_q        <= COL_PAT0;
            acc_q        <= CAND_NONE;
            frame_done_q <= 1'b0;
            cand_q       <= CAND_NONE;
        end else begin
            div_q        <= div_d;
            col_idx_q    <= col_idx_d;
            col_q        <= col_d;
            acc_q        <= acc_d;
            frame_done_q <= frame_done_d;
            cand_q       <= cand_d;
        end
    end

    assign col_o        = col_q;
    assign frame_done_o = frame_done_q;
    assign cand_o       = cand_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame-level debounce.
// Each accepted press emits a one-cycle key_valid pulse, updates key_code,
// and shifts the code into the 4-digit display word.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   col        - active-low column drive, one bit low at a time
//   row        - active-low row sense (already synchronised)
//   key_valid  - one-cycle pulse per accepted press
//   key_code   - code of the last accepted key
//   data       - last four accepted codes, newest in [3:0]
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [COL_W-1:0]  col,
    input  logic [ROW_W-1:0]  row,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic [DATA_W-1:0] data
);

    logic              frame_done;
    logic [CAND_W-1:0] frame_cand;

    keypad_col_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col_scan (
        .clk_i        (clk),
        .rst_i        (rst),
        .row_i        (row),
        .col_o        (col),
        .frame_done_o (frame_done),
        .cand_o       (frame_cand)
    );

    kp_state_e         state_q, state_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [CAND_W-1:0] lat_q, lat_d;

    logic              key_valid_q, key_valid_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              cand_none_c;
    logic              cand_same_c;
    logic [DEB_W-1:0]  deb_inc_c;
    logic              deb_hit_c;
    logic              accept_c;

    // Shared frame decode used by both the next-state and output logic.
    assign cand_none_c = frame_cand[CAND_W-1];
    assign cand_same_c = (frame_cand == lat_q);
    assign deb_inc_c   = deb_q + DEB_W'(1);
    assign deb_hit_c   = (deb_inc_c == DEB_W'(DEBOUNCE));
    assign accept_c    = frame_done && !cand_none_c &&
                         (((state_q == ST_IDLE) && (DEBOUNCE == 1)) ||
                          ((state_q == ST_CONFIRM) && cand_same_c && deb_hit_c));

    // State, debounce count, latched candidate and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            deb_q       <= '0;
            lat_q       <= CAND_NONE;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            deb_q       <= deb_d;
            lat_q       <= lat_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            data_q      <= data_d;
        end
    end

    // Debounce FSM, stepped once per completed frame.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        lat_d   = lat_q;

        if (frame_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (!cand_none_c) begin
                        lat_d = frame_cand;
                        if (DEBOUNCE == 1) begin
                            state_d = ST_HELD;
                            deb_d   = '0;
                        end else begin
                            state_d = ST_CONFIRM;
                            deb_d   = DEB_W'(1);
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (cand_none_c) begin
                        state_d = ST_IDLE;
                        deb_d   = '0;
                        lat_d   = CAND_NONE;
                    end else if (cand_same_c) begin
                        if (deb_hit_c) begin
                            state_d = ST_HELD;
                            deb_d   = '0;
                        end else begin
                            deb_d   = deb_inc_c;
                        end
                    end else begin
                        lat_d = frame_cand;
                        deb_d = DEB_W'(1);
                    end
                end
                ST_HELD: begin
                    // Any key while held, even a different one, is ignored.
                    if (cand_none_c) begin
                        if (DEBOUNCE == 1) begin
                            state_d = ST_IDLE;
                            deb_d   = '0;
                            lat_d   = CAND_NONE;
                        end else begin
                            state_d = ST_RELEASE;
                            deb_d   = DEB_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (cand_none_c) begin
                        if (deb_hit_c) begin
                            state_d = ST_IDLE;
                            deb_d   = '0;
                            lat_d   = CAND_NONE;
                        end else begin
                            deb_d   = deb_inc_c;
                        end
                    end else begin
                        state_d = ST_HELD;
                        deb_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    deb_d   = '0;
                    lat_d   = CAND_NONE;
                end
            endcase
        end
    end

    // Press acceptance: pulse, code and display shift land on the same edge.
    always_comb begin
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        data_d      = data_q;
        if (accept_c) begin
            key_valid_d = 1'b1;
            key_code_d  = frame_cand[CODE_W-1:0];
            data_d      = {data_q[DATA_W-CODE_W-1:0], frame_cand[CODE_W-1:0]};
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign data      = data_q;

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16: clk cycles each column is driven; legal range 2..65535.
REQ-002 SHALL have parameter DEBOUNCE, default 4: consecutive identical scan frames required to accept a press or a release; legal range 1..15.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1: system clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port col, output, 4: column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port row, input, 4: row sense, active-low (external pull-ups), treated as already synchronised.
REQ-008 SHALL have port key_valid, output, 1: one-cycle pulse per accepted key press.
REQ-009 SHALL have port key_code, output, 4: hex code of the last accepted key, held between pulses.
REQ-010 SHALL have port data, output, 16: last four accepted codes, newest in [3:0], directly displayable on the 4-digit hex display.

Function
REQ-011 SHALL step col through 1110, 1101, 1011, 0111 (column index 0..3), then wrap to 1110, each pattern held SCAN_DIV cycles.
REQ-012 SHALL sample row on the last cycle of each column dwell; no other cycle samples row.
REQ-013 SHALL encode a pressed key at row index r (row[r]==0) and column index c as code = 4*r + c.
REQ-014 SHALL form one frame per four column dwells; frame candidate = lowest code seen pressed in that frame, or NONE if no row bit was low.
REQ-015 SHALL evaluate the FSM once per frame, on the cycle after the column-3 sample; states IDLE, CONFIRM, HELD, RELEASE.
REQ-016 IDLE: candidate present -> CONFIRM, latch candidate, count=1; NONE -> stay.
REQ-017 CONFIRM: same candidate -> count+1; different candidate -> relatch, count=1; NONE -> IDLE.
REQ-018 CONFIRM: when count reaches DEBOUNCE -> HELD, with key_valid=1 for exactly one cycle, key_code=candidate, data={data[11:0],candidate}, all updated on the same edge.
REQ-019 DEBOUNCE=1 SHALL accept the press on the first candidate frame: IDLE -> HELD directly, with the REQ-018 outputs.
REQ-020 HELD: NONE -> RELEASE, count=1; any candidate, including a different key -> stay, with no new event (no rollover).
REQ-021 RELEASE: NONE -> count+1, and reaching DEBOUNCE -> IDLE; any candidate -> HELD.
REQ-022 Latency SHALL be the press-acceptance frame evaluation edge plus 0 cycles: key_valid asserts on the evaluation edge itself.
REQ-023 Multiple simultaneous keys SHALL resolve by REQ-014 priority only; no error output.

Reset
REQ-024 On rst, outputs SHALL be: col=1110, key_valid=0, key_code=0, data=0.
REQ-025 On rst, internal state SHALL be: FSM=IDLE, dwell counter=0, column index=0, frame candidate=NONE, debounce count=0.
REQ-026 Reset asserted mid-frame or mid-debounce SHALL discard the partial frame and pending candidate; no key_valid for the next 4*SCAN_DIV cycles after release of rst.
REQ-027 rst SHALL take priority over every other event in the same cycle.

Structure
REQ-028 Shared package keypad_pkg SHALL hold the FSM state enum, the four column patterns, and a NONE candidate encoding (5-bit candidate, MSB=none).
REQ-029 Column drive, dwell counter, row sampling and frame-candidate reduction SHALL live in sub-module keypad_col_scan, outputting frame_done pulse and candidate.
REQ-030 The FSM, debounce counter and output registers SHALL live in keypad_scan.

Verification (SCAN_DIV=4, DEBOUNCE=2, frame=16 cycles)
REQ-031 Hold row=1111 after reset for 64 cycles -> col sequence 1110,1101,1011,0111 repeating every 16 cycles, key_valid never 1.
REQ-032 Press key r=2, c=1 (row[2]=0 only while col=1101) for 3 frames -> one key_valid pulse at the end of frame 2, key_code=9, data=0x0009.
REQ-033 Press 5, release 3 frames, press A, release, press 3, press F -> data=0x5A3F, exactly four pulses.
REQ-034 Bounce: key 7 present in frames 1 and 3, absent in frame 2 -> no pulse until frames 3 and 4 are both present; pulse at end of frame 4.
REQ-035 Press keys 4 and 6 together -> key_code=4; while HELD, release 4 but keep 6 -> no second pulse.
REQ-036 Assert rst during CONFIRM with count=1 -> outputs at reset values, no pulse from the interrupted press.
